// File: rtl/bitrev_arb.sv
// Frame-granular arbiter sharing one bitrev core among NCH valid/ready streams.
// Define BITREV_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module bitrev_arb #(
    parameter int K    = 10,
    parameter int DW   = 32,
    parameter int NCH  = 4,
    parameter int TAGQ = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NCH-1:0]    s_valid_i,
    input  logic [NCH*DW-1:0] s_data_i,
    output logic [NCH-1:0]    s_ready_o,
    output logic [NCH-1:0]    m_valid_o,
    output logic [DW-1:0]     m_data_o,
    input  logic [NCH-1:0]    m_ready_i,
    output logic              core_valid_o,
    output logic [DW-1:0]     core_data_o,
    input  logic              core_ready_i,
    input  logic              core_valid_i,
    input  logic [DW-1:0]     core_data_i,
    output logic              core_ready_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam int            CW        = $clog2(NCH);
    localparam int            TW        = $clog2(TAGQ);
    localparam logic [K-1:0]  LAST_BEAT = '1;
    localparam logic [TW:0]   FULL_CNT  = (TW+1)'(TAGQ);
    localparam logic [CW:0]   NCH_W     = (CW+1)'(NCH);

    typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_grant;
    logic [CW-1:0]   r_last_grant;
    logic [K-1:0]    r_in_cnt;
    logic [K-1:0]    r_out_cnt;
    logic [CW-1:0]   r_tag_mem [TAGQ];
    logic [TW-1:0]   r_wr_ptr;
    logic [TW-1:0]   r_rd_ptr;
    logic [TW:0]     r_count;
    logic            r_err;

    logic [DW-1:0]   w_s_data [NCH];
    logic [CW-1:0]   w_pick;
    logic            w_pick_vld;
    logic [CW:0]     w_rr_sum;
    logic [CW:0]     w_rr_idx;
    logic [CW-1:0]   w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_in_acc;
    logic            w_out_acc;
    logic            w_full;

    // Unpack the flat per-channel input data bus.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_s_data[c] = s_data_i[c*DW +: DW];
        end
    end

    // Grant selection; a later (lower-priority) candidate is overwritten by an earlier one.
    always_comb begin
        w_pick     = r_last_grant;
        w_pick_vld = 1'b0;
        w_rr_sum   = '0;
        w_rr_idx   = '0;
`ifdef BITREV_ARB_FIXED_PRIO_EN
        for (int i = NCH - 1; i >= 0; i--) begin
            w_pick     = s_valid_i[i] ? CW'(i) : w_pick;
            w_pick_vld = w_pick_vld | s_valid_i[i];
        end
`else
        for (int i = NCH; i >= 1; i--) begin
            w_rr_sum   = {1'b0, r_last_grant} + (CW+1)'(i);
            w_rr_idx   = (w_rr_sum >= NCH_W) ? (w_rr_sum - NCH_W) : w_rr_sum;
            w_pick     = s_valid_i[w_rr_idx[CW-1:0]] ? w_rr_idx[CW-1:0] : w_pick;
            w_pick_vld = w_pick_vld | s_valid_i[w_rr_idx[CW-1:0]];
        end
`endif
    end

    assign w_full = (r_count == FULL_CNT);
    assign w_head = r_tag_mem[r_rd_ptr];

    // Input FSM next state and write-side routing.
    always_comb begin
        w_state_nxt  = r_state;
        s_ready_o    = '0;
        core_valid_o = 1'b0;
        core_data_o  = '0;
        w_push       = 1'b0;
        w_in_acc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_full && w_pick_vld) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                core_valid_o       = s_valid_i[r_grant];
                core_data_o        = w_s_data[r_grant];
                s_ready_o[r_grant] = core_ready_i;
                w_in_acc           = s_valid_i[r_grant] & core_ready_i;
                if (w_in_acc && (r_in_cnt == LAST_BEAT)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read-side routing to the owner of the oldest in-flight frame.
    always_comb begin
        m_valid_o    = '0;
        core_ready_o = 1'b0;
        m_data_o     = core_data_i;
        w_out_acc    = 1'b0;
        w_pop        = 1'b0;
        if (r_count != '0) begin
            m_valid_o[w_head] = core_valid_i;
            core_ready_o      = m_ready_i[w_head];
            w_out_acc         = core_valid_i & m_ready_i[w_head];
            w_pop             = w_out_acc & (r_out_cnt == LAST_BEAT);
        end else begin
            m_valid_o    = '0;
            core_ready_o = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, beat counters, tag FIFO and sticky error.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_grant      <= '0;
            r_last_grant <= CW'(NCH - 1);
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
            for (int t = 0; t < TAGQ; t++) begin
                r_tag_mem[t] <= '0;
            end
        end else begin
            if (w_push) begin
                r_grant             <= w_pick;
                r_tag_mem[r_wr_ptr] <= w_pick;
                r_wr_ptr            <= r_wr_ptr + TW'(1);
            end
            if (w_in_acc) begin
                r_in_cnt <= (r_in_cnt == LAST_BEAT) ? '0 : r_in_cnt + K'(1);
                if (r_in_cnt == LAST_BEAT) begin
                    r_last_grant <= r_grant;
                end
            end
            if (w_out_acc) begin
                r_out_cnt <= (r_out_cnt == LAST_BEAT) ? '0 : r_out_cnt + K'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + TW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (TW+1)'(1);
                2'b01:   r_count <= r_count - (TW+1)'(1);
                default: r_count <= r_count;
            endcase
            if ((r_count == '0) && core_valid_i) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_o = (r_state == ST_STREAM) | (r_count != '0);
    assign err_o  = r_err;

endmodule

// File: tb/tb_bitrev_arb.sv
// Directed bench for bitrev_arb; a behavioural stand-in for the bitrev core
// buffers whole frames and replays them in bit-reversed index order.
module tb_bitrev_arb;
    localparam int K    = 4;
    localparam int N    = 1 << K;
    localparam int DW   = 32;
    localparam int NCH  = 4;
    localparam int TAGQ = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NCH-1:0]    s_valid_i;
    logic [NCH*DW-1:0] s_data_i;
    logic [NCH-1:0]    s_ready_o;
    logic [NCH-1:0]    m_valid_o;
    logic [DW-1:0]     m_data_o;
    logic [NCH-1:0]    m_ready_i;
    logic              core_valid_o;
    logic [DW-1:0]     core_data_o;
    logic              core_ready_i;
    logic              core_valid_i;
    logic [DW-1:0]     core_data_i;
    logic              core_ready_o;
    logic              busy_o;
    logic              err_o;

    bitrev_arb #(.K(K), .DW(DW), .NCH(NCH), .TAGQ(TAGQ)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
        .core_valid_i(core_valid_i), .core_data_i(core_data_i), .core_ready_o(core_ready_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] budget;   // frames per channel, ch0 in bits [3:0]
        int          ngr;
        logic [19:0] exp_rr;   // grant order, first grant in bits [3:0]
        logic [19:0] exp_fp;
    } vec_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          budget [NCH];
    int          tx_cnt [NCH];
    logic [31:0] rx [NCH][$];
    logic [31:0] fq [$];
    int          grant_log [$];
    int          wr_cnt, rd_idx, stray;
    bit          rnd, force_cv;
    logic [NCH-1:0] mr_mask;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int brv(input int j);
        int r = 0;
        for (int i = 0; i < K; i++) r[K-1-i] = j[i];
        return r;
    endfunction

    function automatic logic [31:0] expv(input int c, input int m);
        return {4'hA, 4'(c), 24'((m / N) * N + brv(m % N))};
    endfunction

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            s_valid_i[c] = (tx_cnt[c] < budget[c] * N) && (!rnd || $urandom_range(0, 3) != 0);
            s_data_i[c*DW +: DW] = {4'hA, 4'(c), 24'(tx_cnt[c])};
        end
        core_ready_i = !rnd || ($urandom_range(0, 3) != 0);
        if (fq.size() >= N) begin
            core_valid_i = force_cv || !rnd || ($urandom_range(0, 2) != 0);
            core_data_i  = fq[brv(rd_idx)];
        end else begin
            core_valid_i = force_cv;
            core_data_i  = 32'h0;
        end
        m_ready_i = mr_mask & (rnd ? 4'($urandom_range(0, 15)) : 4'hF);
    endtask

    task automatic tick();
        logic in_hs, out_hs;
        logic [31:0] din, md;
        logic [NCH-1:0] mv, sr, shs;
        int g;
        @(negedge clk_i);
        in_hs  = core_valid_o && core_ready_i;
        din    = core_data_o;
        out_hs = core_valid_i && core_ready_o;
        mv     = m_valid_o;
        md     = m_data_o;
        sr     = s_ready_o;
        shs    = s_valid_i & s_ready_o;
        if ($countones(mv) > 1) stray++;
        for (int c = 0; c < NCH; c++) if (mv[c] && budget[c] == 0) stray++;
        @(posedge clk_i);
        if (!rst_ni) begin
            fq.delete();
            wr_cnt = 0;
            rd_idx = 0;
        end else begin
            if (in_hs) begin
                if (wr_cnt == 0) begin
                    g = -1;
                    for (int c = 0; c < NCH; c++) if (sr[c]) g = c;
                    grant_log.push_back(g);
                end
                fq.push_back(din);
                wr_cnt = (wr_cnt == N - 1) ? 0 : wr_cnt + 1;
            end
            for (int c = 0; c < NCH; c++) if (shs[c]) tx_cnt[c]++;
            if (out_hs) begin
                for (int c = 0; c < NCH; c++) if (mv[c]) rx[c].push_back(md);
                rd_idx++;
                if (rd_idx == N) begin
                    rd_idx = 0;
                    for (int i = 0; i < N; i++) void'(fq.pop_front());
                end
            end
        end
        #1;
        drive();
    endtask

    task automatic reset_all(input logic [15:0] b);
        rst_ni = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            budget[c] = int'(b[4*c +: 4]);
            tx_cnt[c] = 0;
            rx[c].delete();
        end
        grant_log.delete();
        fq.delete();
        wr_cnt = 0; rd_idx = 0; stray = 0; force_cv = 1'b0; rnd = 1'b0; mr_mask = 4'hF;
        drive();
        repeat (2) tick();
        rst_ni = 1'b1;
        drive();
    endtask

    function automatic bit all_done();
        bit d = (busy_o == 1'b0);
        for (int c = 0; c < NCH; c++)
            if (tx_cnt[c] != budget[c] * N || rx[c].size() != budget[c] * N) d = 1'b0;
        return d;
    endfunction

    task automatic drain(input int limit);
        int t = 0;
        bit done = 1'b0;
        while (!done && t < limit) begin
            tick();
            t++;
            done = all_done();
        end
        chk("drain_complete", 32'(done), 32'd1);
    endtask

    task automatic check_rx();
        int bad;
        for (int c = 0; c < NCH; c++) begin
            bad = 0;
            chk($sformatf("rx_len_ch%0d", c), 32'(rx[c].size()), 32'(budget[c] * N));
            for (int m = 0; m < rx[c].size(); m++) if (rx[c][m] !== expv(c, m)) bad++;
            chk($sformatf("rx_data_bad_beats_ch%0d", c), 32'(bad), 32'd0);
        end
        chk("stray_m_valid", 32'(stray), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready_o), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
        chk({tag, "_core_valid"}, 32'(core_valid_o), 32'd0);
        chk({tag, "_core_ready"}, 32'(core_ready_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        vec_t tbl [4];
        logic [19:0] eo;
        int t;
        tbl[0] = '{16'h1112, 5, 20'h03210, 20'h32100};
        tbl[1] = '{16'h0300, 3, 20'h00222, 20'h00222};
        tbl[2] = '{16'h2020, 4, 20'h03131, 20'h03311};
        tbl[3] = '{16'h2001, 3, 20'h00330, 20'h00330};

        // Reset held for 4 cycles with every channel requesting.
        rst_ni = 1'b0;
        for (int c = 0; c < NCH; c++) begin budget[c] = 1; tx_cnt[c] = 0; end
        wr_cnt = 0; rd_idx = 0; stray = 0; force_cv = 1'b0; rnd = 1'b0; mr_mask = 4'hF;
        drive();
        repeat (4) tick();
        chk_reset_outputs("reset");

        // Arbitration table: grant order and per-channel reordered data.
        for (int r = 0; r < 4; r++) begin
            reset_all(tbl[r].budget);
            drain(800);
`ifdef BITREV_ARB_FIXED_PRIO_EN
            eo = tbl[r].exp_fp;
`else
            eo = tbl[r].exp_rr;
`endif
            chk($sformatf("row%0d_grant_count", r), 32'(grant_log.size()), 32'(tbl[r].ngr));
            for (int i = 0; i < tbl[r].ngr && i < grant_log.size(); i++)
                chk($sformatf("row%0d_grant%0d", r, i), 32'(grant_log[i]), 32'(eo[4*i +: 4]));
            check_rx();
            chk($sformatf("row%0d_err", r), 32'(err_o), 32'd0);
        end

        // Tag FIFO full: two frames accepted, third waits for the first pop.
        reset_all(16'h0111);
        mr_mask = 4'h0;
        drive();
        repeat (60) tick();
        chk("full_grant_count", 32'(grant_log.size()), 32'd2);
        chk("full_ch2_beats", 32'(tx_cnt[2]), 32'd0);
        chk("full_busy", 32'(busy_o), 32'd1);
        mr_mask = 4'h1;
        drive();
        t = 0;
        while (grant_log.size() < 3 && t < 60) begin tick(); t++; end
        chk("full_third_grant_seen", 32'(grant_log.size()), 32'd3);
        chk("full_third_grant_latency", 32'(t), 32'(N + 2));
        chk("full_ch0_drained_first", 32'(rx[0].size()), 32'(N));
        if (grant_log.size() >= 3) chk("full_third_grant_ch", 32'(grant_log[2]), 32'd2);
        mr_mask = 4'hF;
        drive();
        drain(400);
        check_rx();

        // Random gaps on channel 1 across two frames.
        reset_all(16'h0020);
        rnd = 1'b1;
        drive();
        drain(3000);
        rnd = 1'b0;
        chk("bp_grant_count", 32'(grant_log.size()), 32'd2);
        check_rx();

        // Core output with no frame in flight sets the sticky error.
        reset_all(16'h0000);
        force_cv = 1'b1;
        drive();
        chk("err_before_edge", 32'(err_o), 32'd0);
        chk("err_no_route", 32'(m_valid_o), 32'd0);
        tick();
        chk("err_set", 32'(err_o), 32'd1);
        force_cv = 1'b0;
        drive();
        repeat (3) tick();
        chk("err_sticky", 32'(err_o), 32'd1);
        rst_ni = 1'b0;
        drive();
        tick();
        chk("err_cleared_by_reset", 32'(err_o), 32'd0);
        rst_ni = 1'b1;
        drive();

        // Reset in the middle of a frame.
        reset_all(16'h0001);
        t = 0;
        while (tx_cnt[0] < N / 2 && t < 40) begin tick(); t++; end
        chk("mid_beats_reached", 32'(tx_cnt[0]), 32'(N / 2));
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        drive();
        tick();
        chk_reset_outputs("mid_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bitrev_arb.md
# bitrev_arb

Frame-granular arbiter that shares one `bitrev` core (2^K-point, double-buffered bit-reversal reorder) among NCH independent valid/ready sample streams. It grants one requester for a full N = 2^K beat frame, records the owner in a small tag FIFO, and routes each reordered output frame back to the owning channel. It sits between the per-channel DMA/stream front-ends and the single `bitrev` instance.

## Interface
- K, 10, log2 frame length; N = 2^K beats per frame
- DW, 32, sample width in bits
- NCH, 4, number of requesting channels (2..16)
- TAGQ, 2, tag FIFO depth = max frames in flight inside the core (power of two, ≥2)

- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- s_valid_i  in  NCH  per-channel input valid
- s_data_i  in  NCH*DW  per-channel input data, channel c at [c*DW +: DW]
- s_ready_o  out  NCH  per-channel input ready
- m_valid_o  out  NCH  per-channel output valid
- m_data_o  out  DW  output data, shared by all channels
- m_ready_i  in  NCH  per-channel output ready
- core_valid_o / core_data_o [DW] / core_ready_i  out/out/in  write side of `bitrev`
- core_valid_i / core_data_i [DW] / core_ready_o  in/in/out  read side of `bitrev`
- busy_o  out  1  any frame granted or in flight
- err_o  out  1  sticky: core produced data with tag FIFO empty

## Operation
- Input FSM states: IDLE, STREAM.
- IDLE: when tag FIFO not full and any s_valid_i high, pick channel g (round-robin, search starts at last_grant+1 mod NCH), register g, push tag g into FIFO, go STREAM. No handshake completes in IDLE.
- STREAM: core_valid_o = s_valid_i[g], core_data_o = s_data_i[g], s_ready_o[g] = core_ready_i; all other s_ready_o = 0. Beat counter in_cnt (K bits) increments per accepted beat; on the beat with in_cnt = N-1, counter wraps to 0, last_grant ← g, go IDLE.
- Output side: when tag FIFO non-empty, head tag h selects routing: m_valid_o[h] = core_valid_i, core_ready_o = m_ready_i[h], m_data_o = core_data_i; other m_valid_o = 0. Counter out_cnt counts accepted beats; at N-1 wraps and pops the tag.
- Tag FIFO empty: core_ready_o = 0, all m_valid_o = 0; if core_valid_i = 1, set err_o (cleared only by reset).
- Simultaneous push (IDLE grant) and pop (last output beat): both take effect, occupancy unchanged.
- Frames leave in the order they entered; a channel may own several in-flight frames.
- busy_o = (state = STREAM) | (FIFO occupancy ≠ 0).

## Timing
- Reset values: state IDLE, in_cnt/out_cnt 0, last_grant NCH-1 (so channel 0 wins first), FIFO empty, err_o 0; hence s_ready_o 0, m_valid_o 0, core_valid_o 0, core_ready_o 0, busy_o 0.
- Arbitration: 1 cycle bubble (IDLE) per frame; first beat can transfer the cycle after the grant edge.
- Datapath: zero-cycle combinational pass-through in both directions; no registers on data.
- Grant never changes mid-frame regardless of other requests or s_valid_i dropping.
- Reset asserted mid-frame: all state returns to reset values at that edge; partial frames are discarded (core shares rst_ni).

## Configuration
- BITREV_ARB_FIXED_PRIO_EN: defined → IDLE grants lowest-indexed requesting channel (last_grant ignored, still maintained). Undefined → round-robin as above.

## Test plan
- Reset: hold rst_ni = 0 4 cycles with all s_valid_i = 1 → s_ready_o = 0, m_valid_o = 0, busy_o = 0, err_o = 0.
- Single channel: ch2 sends values 0..1023 (K=10) → ch2 receives 0, 512, 256, … (bit-reversed index), m_valid_o[0,1,3] never high.
- Round-robin: ch0..ch3 all requesting continuously → grant order 0,1,2,3,0; each output frame on its owner with data tagged by channel in upper bits; with BITREV_ARB_FIXED_PRIO_EN, order 0,0,0….
- Tag full: m_ready_i = 0 all, 3 channels requesting → exactly TAGQ=2 frames accepted, IDLE holds; releasing m_ready_i[owner] of first frame → third grant follows pop.
- Backpressure: random s_valid_i/m_ready_i gaps on ch1 → no lost/duplicated beats, in_cnt/out_cnt wrap exactly at 1023.
- Error/reset: force core_valid_i = 1 with FIFO empty → err_o = 1 next edge, stays until rst_ni low; reset at beat 500 of a frame → all outputs back to reset values next cycle.
